// File: rtl/bee_sprite_render.sv
// ---------------------------------------------------------------------------
// bee_sprite_render
//   Pixel-pipeline stage in front of the bee sprite ROM (34x27, 8-bit pixels,
//   1-cycle registered read). Hit-tests the scan position against the bee's
//   bounding box, generates the ROM address, and realigns the returned ROM
//   data with a delayed hit flag. Also owns the bee's on-screen position:
//   an invaders-style motion FSM steps it sideways once per frame, bounces
//   at the screen edges and drops one step per bounce until it lands.
//
//   Coordinate to pixel latency is fixed at 3 cycles:
//     N   : combinational hit test on i_x / i_y / i_active
//     N+1 : o_rom_addr registered
//     N+2 : ROM returns data
//     N+3 : o_pix_data / o_pix_on registered
//
// Optional feature (macro BEE_TRANSPARENT_KEY_EN):
//   when defined, ROM pixels equal to KEY_COLOR are treated as transparent
//   (o_pix_on=0, o_pix_data=0) so the background shows through.
//
// Ports:
//   i_clk2        pixel clock (shared with the sprite ROM)
//   i_rst_n       asynchronous active-low reset
//   i_x, i_y      current scan column / row
//   i_active      scan position is inside the visible area
//   i_frame_tick  one-cycle pulse at start of vertical blank
//   i_move_en     1 = motion FSM advances on frame tick
//   o_rom_addr    sprite ROM address
//   i_rom_data    sprite ROM data
//   o_pix_data    sprite pixel colour
//   o_pix_on      sprite pixel valid
//   o_bee_x/y     sprite top-left position
//   o_dir         0 = moving right, 1 = moving left
//   o_landed      sprite can drop no further
// ---------------------------------------------------------------------------
//   state    | meaning
//   S_RIGHT  | stepping right each enabled frame tick
//   S_LEFT   | stepping left each enabled frame tick
//   S_LANDED | reached the bottom; position frozen until reset
// ---------------------------------------------------------------------------
module bee_sprite_render #(
  parameter int         SPR_W     = 34,
  parameter int         SPR_H     = 27,
  parameter int         H_ACTIVE  = 640,
  parameter int         V_ACTIVE  = 480,
  parameter int         START_X   = 100,
  parameter int         START_Y   = 50,
  parameter int         STEP      = 4,
  parameter int         DROP      = 8,
  parameter logic [7:0] KEY_COLOR = 8'h00
) (
  input  logic       i_clk2,
  input  logic       i_rst_n,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_active,
  input  logic       i_frame_tick,
  input  logic       i_move_en,
  output logic [9:0] o_rom_addr,
  input  logic [7:0] i_rom_data,
  output logic [7:0] o_pix_data,
  output logic       o_pix_on,
  output logic [9:0] o_bee_x,
  output logic [9:0] o_bee_y,
  output logic       o_dir,
  output logic       o_landed
);

  typedef enum logic [1:0] {
    S_RIGHT  = 2'd0,
    S_LEFT   = 2'd1,
    S_LANDED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] bx_q, bx_d;
  logic [9:0] by_q, by_d;
  logic       dir_q, dir_d;

  logic [9:0] addr_q, addr_d;
  logic       hit1_q, hit2_q;
  logic [7:0] pix_data_q, pix_data_d;
  logic       pix_on_q, pix_on_d;

  // ---------------- stage 0: hit test and address ----------------
  // 11-bit compares so bx+SPR_W / by+SPR_H cannot wrap near the screen edge.
  logic [10:0] x11, y11, bx11, by11;
  logic        hit;
  logic [9:0]  dx, dy;

  assign x11  = {1'b0, i_x};
  assign y11  = {1'b0, i_y};
  assign bx11 = {1'b0, bx_q};
  assign by11 = {1'b0, by_q};

  assign hit = i_active &&
               (x11 >= bx11) && (x11 < bx11 + 11'(SPR_W)) &&
               (y11 >= by11) && (y11 < by11 + 11'(SPR_H));

  assign dx = i_x - bx_q;
  assign dy = i_y - by_q;

  // Offsets are only meaningful on a hit; outside the box the address is 0.
  assign addr_d = hit ? (dy * 10'(SPR_W) + dx) : 10'd0;

  // ---------------- stage 3: pixel output ----------------
  always_comb begin
    pix_data_d = 8'h00;
    pix_on_d   = 1'b0;
`ifdef BEE_TRANSPARENT_KEY_EN
    if (hit2_q && (i_rom_data != KEY_COLOR)) begin
      pix_data_d = i_rom_data;
      pix_on_d   = 1'b1;
    end
`else
    if (hit2_q) begin
      pix_data_d = i_rom_data;
      pix_on_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q     <= 10'd0;
      hit1_q     <= 1'b0;
      hit2_q     <= 1'b0;
      pix_data_q <= 8'h00;
      pix_on_q   <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      hit1_q     <= hit;
      hit2_q     <= hit1_q;
      pix_data_q <= pix_data_d;
      pix_on_q   <= pix_on_d;
    end
  end

  // ---------------- motion FSM ----------------
  logic   bounce;
  state_t bounce_state;

  always_comb begin
    state_d      = state_q;
    bx_d         = bx_q;
    by_d         = by_q;
    dir_d        = dir_q;
    bounce       = 1'b0;
    bounce_state = state_q;

    if (i_frame_tick && i_move_en) begin
      case (state_q)
        S_RIGHT: begin
          if (bx11 + 11'(STEP + SPR_W) <= 11'(H_ACTIVE)) begin
            bx_d = bx_q + 10'(STEP);
          end else begin
            bx_d         = 10'(H_ACTIVE - SPR_W);
            bounce       = 1'b1;
            bounce_state = S_LEFT;
          end
        end
        S_LEFT: begin
          if (bx11 >= 11'(STEP)) begin
            bx_d = bx_q - 10'(STEP);
          end else begin
            bx_d         = 10'd0;
            bounce       = 1'b1;
            bounce_state = S_RIGHT;
          end
        end
        default: ;
      endcase

      // Landing leaves dir untouched so o_dir reports the last travel direction.
      if (bounce) begin
        if (by11 + 11'(DROP + SPR_H) <= 11'(V_ACTIVE)) begin
          by_d    = by_q + 10'(DROP);
          state_d = bounce_state;
          dir_d   = (bounce_state == S_LEFT);
        end else begin
          by_d    = 10'(V_ACTIVE - SPR_H);
          state_d = S_LANDED;
        end
      end
    end
  end

  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_RIGHT;
      bx_q    <= 10'(START_X);
      by_q    <= 10'(START_Y);
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dir_q   <= dir_d;
    end
  end

  assign o_rom_addr = addr_q;
  assign o_pix_data = pix_data_q;
  assign o_pix_on   = pix_on_q;
  assign o_bee_x    = bx_q;
  assign o_bee_y    = by_q;
  assign o_dir      = dir_q;
  assign o_landed   = (state_q == S_LANDED);

endmodule

// File: tb/tb_bee_sprite_render.sv
module tb_bee_sprite_render;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] x, y;
  logic       active, tick, move_en;
  logic [9:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] pix_data;
  logic       pix_on;
  logic [9:0] bee_x, bee_y;
  logic       dir, landed;

  int errors = 0;
  int checks = 0;

  always #20 clk = ~clk;

  bee_sprite_render dut (
    .i_clk2      (clk),
    .i_rst_n     (rst_n),
    .i_x         (x),
    .i_y         (y),
    .i_active    (active),
    .i_frame_tick(tick),
    .i_move_en   (move_en),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .o_pix_data  (pix_data),
    .o_pix_on    (pix_on),
    .o_bee_x     (bee_x),
    .o_bee_y     (bee_y),
    .o_dir       (dir),
    .o_landed    (landed)
  );

  // Sprite ROM stand-in: ROM[a] = a[7:0] + 8'h3C, one-cycle registered read.
  always_ff @(posedge clk) rom_data <= rom_addr[7:0] + 8'h3C;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_tick(input logic en);
    @(negedge clk);
    tick = 1'b1; move_en = en;
    @(negedge clk);
    tick = 1'b0; move_en = 1'b0;
  endtask

  task automatic chk_pos(input string name, input int ex, input int ey, input int ed, input int el);
    chk({name, ".x"}, int'(bee_x), ex);
    chk({name, ".y"}, int'(bee_y), ey);
    chk({name, ".dir"}, int'(dir), ed);
    chk({name, ".landed"}, int'(landed), el);
  endtask

  typedef struct {
    int x; int y; bit act;
    int exp_addr; bit exp_on; int exp_data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n;
    bit key_en;
`ifdef BEE_TRANSPARENT_KEY_EN
    key_en = 1'b1;
`else
    key_en = 1'b0;
`endif
    //          x    y  act  addr on  data
    vecs[0] = '{100, 50, 1,    0, 1, 8'h3C};
    vecs[1] = '{133, 76, 1,  917, 1, 8'hD1};
    vecs[2] = '{134, 76, 1,    0, 0, 0};
    vecs[3] = '{110, 60, 0,    0, 0, 0};
    vecs[4] = '{ 99, 50, 1,    0, 0, 0};
    vecs[5] = '{100, 77, 1,    0, 0, 0};
    vecs[6] = '{101, 51, 1,   35, 1, 8'h5F};
    vecs[7] = '{116, 70, 1,  696, 1, 8'hF4};
    // ROM[196] = 8'h00 = key colour
    vecs[8] = '{126, 55, 1,  196, !key_en, 0};

    rst_n = 1'b0; x = '0; y = '0; active = 0; tick = 0; move_en = 0;
    repeat (3) @(negedge clk);
    chk("rst.addr", int'(rom_addr), 0);
    chk("rst.pix_on", int'(pix_on), 0);
    chk("rst.pix_data", int'(pix_data), 0);
    chk_pos("rst", 100, 50, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven pixel path: addr at N+1, pixel at N+3.
    for (int i = 0; i < 9; i++) begin
      x = 10'(vecs[i].x); y = 10'(vecs[i].y); active = vecs[i].act;
      @(negedge clk);
      chk($sformatf("v%0d.addr", i), int'(rom_addr), vecs[i].exp_addr);
      active = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("v%0d.pix_on", i), int'(pix_on), int'(vecs[i].exp_on));
      chk($sformatf("v%0d.pix_data", i), int'(pix_data), vecs[i].exp_data);
      @(negedge clk);
    end

    // Frame tick coincident with an in-sprite pixel uses the old position.
    @(negedge clk);
    x = 10'd100; y = 10'd50; active = 1'b1; tick = 1'b1; move_en = 1'b1;
    @(negedge clk);
    tick = 1'b0; move_en = 1'b0; active = 1'b0;
    chk("coinc.addr", int'(rom_addr), 0);
    chk_pos("coinc", 104, 50, 0, 0);
    @(negedge clk); @(negedge clk);
    chk("coinc.pix_on", int'(pix_on), 1);
    // New position: (100,50) now misses, (104,50) hits at address 0.
    x = 10'd102; y = 10'd51; active = 1'b1;
    @(negedge clk);
    chk("moved.miss_addr", int'(rom_addr), 0);
    x = 10'd105; y = 10'd51;
    @(negedge clk);
    active = 1'b0;
    chk("moved.hit_addr", int'(rom_addr), 35);
    @(negedge clk);
    chk("moved.miss_on", int'(pix_on), 0);

    // Tick with motion disabled does nothing.
    do_tick(1'b0);
    chk_pos("frozen", 104, 50, 0, 0);

    // Back to start, then step right to the edge.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    while (bee_x != 10'd604 && n < 300) begin do_tick(1'b1); n++; end
    chk("run_right.ticks", n, 126);
    chk_pos("pre_bounce_r", 604, 50, 0, 0);
    do_tick(1'b1);
    chk_pos("bounce_r", 606, 58, 1, 0);
    do_tick(1'b1);
    chk_pos("left_step", 602, 58, 1, 0);

    n = 0;
    while (bee_x != 10'd2 && n < 300) begin do_tick(1'b1); n++; end
    chk("run_left.ticks", n, 150);
    do_tick(1'b1);
    chk_pos("bounce_l", 0, 66, 0, 0);
    do_tick(1'b0);
    chk_pos("bounce_l.frozen", 0, 66, 0, 0);

    // Keep bouncing until landing (51st bounce, at the right edge).
    n = 0;
    while (!landed && n < 12000) begin do_tick(1'b1); n++; end
    chk_pos("landed", 606, 453, 0, 1);
    repeat (3) do_tick(1'b1);
    chk_pos("landed.hold", 606, 453, 0, 1);

    // Sprite pixels in flight at the landed position, then reset.
    x = 10'd606; y = 10'd453; active = 1'b1;
    repeat (4) @(negedge clk);
    chk("inflight.pix_on", int'(pix_on), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.pix_on", int'(pix_on), 0);
    chk("midrst.addr", int'(rom_addr), 0);
    chk_pos("midrst", 100, 50, 0, 0);
    active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d.pix_on", i), int'(pix_on), 0);
    end
    x = 10'd100; y = 10'd50; active = 1'b1;
    @(negedge clk);
    active = 1'b0;
    @(negedge clk);
    chk("post_rst.pre_on", int'(pix_on), 0);
    @(negedge clk);
    chk("post_rst.hit_on", int'(pix_on), 1);
    chk("post_rst.hit_data", int'(pix_data), 8'h3C);
    // Direction after reset is right again.
    do_tick(1'b1);
    chk_pos("post_rst.step", 104, 50, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
